// File: rtl/cfg_dprio_rdmux_pkg.sv
// Shared types and constants for the N-channel DPRIO readdata mux.
package cfg_dprio_rdmux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_SEL = 2'b01;
   localparam logic [1:0] ERR_TMO = 2'b10;

   // Wait-counter width; never below one bit so a disabled timeout still elaborates.
   function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
      int unsigned w;
      w = $clog2(timeout_cycles + 1);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/cfg_dprio_onehot_mux.sv
// AND-OR one-hot readdata mux with a one-hot legality flag on the select.
module cfg_dprio_onehot_mux #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_CH     = 4
) (
   input  logic [NUM_CH-1:0]            sel,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata,
   output logic [DATA_WIDTH-1:0]        rdata_c,
   output logic                         is_onehot_c
);

   logic seen;
   logic multi;

   always_comb begin
      rdata_c     = '0;
      seen        = 1'b0;
      multi       = 1'b0;
      is_onehot_c = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         rdata_c = rdata_c | (ch_rdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel[i]}});
         if (sel[i]) begin
            multi = multi | seen;
            seen  = 1'b1;
         end
      end
      is_onehot_c = seen & ~multi;
   end

endmodule

// File: rtl/cfg_dprio_readdata_mux_pipe.sv
// N-channel DPRIO readdata mux: one-hot select check, wait for the selected
// rvalid with optional timeout, registered single-cycle response.
module cfg_dprio_readdata_mux_pipe
   import cfg_dprio_rdmux_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         read_req,
   input  logic [NUM_CH-1:0]            sel,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata,
   input  logic [NUM_CH-1:0]            ch_rvalid,
   output logic                         busy,
   output logic                         rdata_valid,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic [1:0]                   err_code
);

   localparam int unsigned CW       = cnt_width(TIMEOUT_CYCLES);
   localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CW-1:0] TMO_LAST = TMO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX  = '1;

   state_t              state;
   logic [NUM_CH-1:0]   sel_q;
   logic [CW-1:0]       cnt;
   logic [NUM_CH-1:0]   mux_sel_c;
   logic [DATA_WIDTH-1:0] mux_rdata_c;
   logic                mux_onehot_c;

   // Raw select is checked while idle; the captured select steers data afterwards.
   assign mux_sel_c = (state == IDLE) ? sel : sel_q;

   cfg_dprio_onehot_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_CH     (NUM_CH)
   ) u_mux (
      .sel         (mux_sel_c),
      .ch_rdata    (ch_rdata),
      .rdata_c     (mux_rdata_c),
      .is_onehot_c (mux_onehot_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         rdata_valid <= 1'b0;
         data_out    <= '0;
         err_code    <= ERR_OK;
         sel_q       <= '0;
         cnt         <= '0;
      end else begin
         rdata_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (read_req) begin
                  sel_q <= sel;
                  busy  <= 1'b1;
                  if (mux_onehot_c) begin
                     state <= WAIT;
                     cnt   <= '0;
                  end else begin
                     state       <= RESP;
                     data_out    <= '0;
                     err_code    <= ERR_SEL;
                     rdata_valid <= 1'b1;
                  end
               end
            end
            WAIT: begin
               // A valid arriving in the final wait cycle beats the timeout.
               if (|(ch_rvalid & sel_q)) begin
                  state       <= RESP;
                  data_out    <= mux_rdata_c;
                  err_code    <= ERR_OK;
                  rdata_valid <= 1'b1;
               end else if (TMO_EN && (cnt == TMO_LAST)) begin
                  state       <= RESP;
                  data_out    <= '0;
                  err_code    <= ERR_TMO;
                  rdata_valid <= 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_dprio_readdata_mux_pipe.sv
// Self-checking bench: transaction-level model compared every cycle plus directed literal checks.
module tb_cfg_dprio_readdata_mux_pipe;

   localparam int DW  = 16;
   localparam int NCH = 4;
   localparam int TMO = 8;

   logic              clk;
   logic              rst_n;
   logic              read_req;
   logic [NCH-1:0]    sel;
   logic [NCH*DW-1:0] ch_rdata;
   logic [NCH-1:0]    ch_rvalid;
   logic              busy;
   logic              rdata_valid;
   logic [DW-1:0]     data_out;
   logic [1:0]        err_code;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int            resp_cyc_q[$];
   logic [DW-1:0] resp_dat_q[$];

   cfg_dprio_readdata_mux_pipe #(
      .DATA_WIDTH     (DW),
      .NUM_CH         (NCH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .read_req    (read_req),
      .sel         (sel),
      .ch_rdata    (ch_rdata),
      .ch_rvalid   (ch_rvalid),
      .busy        (busy),
      .rdata_valid (rdata_valid),
      .data_out    (data_out),
      .err_code    (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding read, aged in cycles.
   bit            m_wait = 0;
   bit            m_resp = 0;
   int            m_age  = 0;
   int            m_idx  = 0;
   logic [DW-1:0] m_data = '0;
   logic [1:0]    m_err  = 2'b00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wait = 0; m_resp = 0; m_age = 0; m_data = '0; m_err = 2'b00;
      end else if (m_resp) begin
         m_resp = 0;
      end else if (m_wait) begin
         if (ch_rvalid[m_idx]) begin
            m_data = ch_rdata[m_idx*DW +: DW]; m_err = 2'b00; m_wait = 0; m_resp = 1;
         end else if (m_age == TMO - 1) begin
            m_data = '0; m_err = 2'b10; m_wait = 0; m_resp = 1;
         end else begin
            m_age++;
         end
      end else if (read_req) begin
         if ($countones(sel) == 1) begin
            m_wait = 1; m_age = 0;
            for (int i = 0; i < NCH; i++) if (sel[i]) m_idx = i;
         end else begin
            m_data = '0; m_err = 2'b01; m_resp = 1;
         end
      end
   end

   always @(negedge clk) begin
      check("model_rdata_valid", 32'(rdata_valid), 32'(m_resp));
      check("model_busy",        32'(busy),        32'(m_wait | m_resp));
      check("model_data_out",    32'(data_out),    32'(m_data));
      check("model_err_code",    32'(err_code),    32'(m_err));
      if (rdata_valid === 1'b1) begin
         resp_cyc_q.push_back(cyc);
         resp_dat_q.push_back(data_out);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic [NCH-1:0] s, output int c0);
      read_req = 1'b1;
      sel      = s;
      c0       = cyc;
      tick();
      read_req = 1'b0;
      sel      = '0;
   endtask

   task automatic wait_resp(input int budget, output int rc);
      rc = -1;
      for (int i = 0; i < budget; i++) begin
         if (rdata_valid === 1'b1) begin
            rc = cyc;
            break;
         end
         tick();
      end
      if (rc < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_resp: no rdata_valid within %0d cycles", budget);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int rc;
      int n0;

      rst_n     = 1'b0;
      read_req  = 1'b0;
      sel       = '0;
      ch_rdata  = '0;
      ch_rvalid = '0;
      repeat (3) tick();
      check("reset_busy",  32'(busy),        32'd0);
      check("reset_valid", 32'(rdata_valid), 32'd0);
      check("reset_data",  32'(data_out),    32'd0);
      check("reset_err",   32'(err_code),    32'd0);
      rst_n = 1'b1;
      tick();

      // Normal read: rvalid three cycles after the request.
      do_req(4'b0100, c0);
      check("normal_busy_after_req", 32'(busy), 32'd1);
      tick(); tick();
      ch_rdata[2*DW +: DW] = 16'hA5C3;
      ch_rvalid = 4'b0100;
      tick();
      ch_rvalid = '0;
      wait_resp(4, rc);
      check("normal_latency", 32'(rc - c0), 32'd4);
      check("normal_data",    32'(data_out), 32'h0000A5C3);
      check("normal_err",     32'(err_code), 32'd0);
      check("normal_busy",    32'(busy),     32'd1);
      tick();
      check("normal_single_pulse", 32'(rdata_valid), 32'd0);
      check("normal_hold",         32'(data_out),    32'h0000A5C3);
      check("normal_idle",         32'(busy),        32'd0);

      // Timeout with no rvalid.
      do_req(4'b1000, c0);
      wait_resp(20, rc);
      check("tmo_latency", 32'(rc - c0), 32'(TMO + 1));
      check("tmo_err",     32'(err_code), 32'd2);
      check("tmo_data",    32'(data_out), 32'd0);
      tick();

      // Valid in the last wait cycle beats the timeout.
      do_req(4'b1000, c0);
      repeat (TMO - 1) tick();
      ch_rdata[3*DW +: DW] = 16'hBEEF;
      ch_rvalid = 4'b1000;
      tick();
      ch_rvalid = '0;
      wait_resp(4, rc);
      check("lastwait_latency", 32'(rc - c0), 32'(TMO + 1));
      check("lastwait_err",     32'(err_code), 32'd0);
      check("lastwait_data",    32'(data_out), 32'h0000BEEF);
      tick();

      // Bad selects: none and two bits set.
      do_req(4'b0000, c0);
      wait_resp(4, rc);
      check("badsel0_latency", 32'(rc - c0), 32'd1);
      check("badsel0_err",     32'(err_code), 32'd1);
      check("badsel0_data",    32'(data_out), 32'd0);
      tick();
      do_req(4'b0110, c0);
      wait_resp(4, rc);
      check("badsel2_latency", 32'(rc - c0), 32'd1);
      check("badsel2_err",     32'(err_code), 32'd1);
      tick();

      // Non-selected channel valid is ignored.
      n0 = resp_cyc_q.size();
      do_req(4'b0001, c0);
      ch_rdata[3*DW +: DW] = 16'hFFFF;
      ch_rvalid = 4'b1000;
      tick();
      ch_rvalid = '0;
      tick();
      ch_rdata[0 +: DW] = 16'h1234;
      ch_rvalid = 4'b0001;
      tick();
      ch_rvalid = '0;
      wait_resp(4, rc);
      check("nonsel_data", 32'(data_out), 32'h00001234);
      check("nonsel_err",  32'(err_code), 32'd0);
      repeat (3) tick();
      check("nonsel_count", 32'(resp_cyc_q.size() - n0), 32'd1);

      // Back-to-back with read_req held high.
      n0 = resp_cyc_q.size();
      c0 = cyc;
      read_req = 1'b1;
      sel = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         ch_rvalid = '0;
         tick();
         ch_rdata[1*DW +: DW] = 16'(16'h1000 + k);
         ch_rvalid = 4'b0010;
         tick();
         ch_rdata[1*DW +: DW] = 16'hDEAD;
         ch_rvalid = 4'b0010;
         tick();
      end
      read_req = 1'b0;
      sel = '0;
      ch_rvalid = '0;
      repeat (3) tick();
      check("b2b_count", 32'(resp_cyc_q.size() - n0), 32'd4);
      if (resp_cyc_q.size() - n0 == 4) begin
         for (int k = 0; k < 4; k++) begin
            check("b2b_cycle", 32'(resp_cyc_q[n0+k] - c0), 32'(3*k + 2));
            check("b2b_data",  32'(resp_dat_q[n0+k]),      32'(16'h1000 + k));
         end
      end

      // Reset during WAIT aborts without a response.
      do_req(4'b1000, c0);
      tick(); tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_busy",  32'(busy),        32'd0);
      check("rst_valid", 32'(rdata_valid), 32'd0);
      check("rst_data",  32'(data_out),    32'd0);
      check("rst_err",   32'(err_code),    32'd0);
      n0 = resp_cyc_q.size();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (TMO + 3) tick();
      check("rst_no_resp", 32'(resp_cyc_q.size() - n0), 32'd0);

      do_req(4'b0010, c0);
      ch_rdata[1*DW +: DW] = 16'h4321;
      ch_rvalid = 4'b0010;
      tick();
      ch_rvalid = '0;
      wait_resp(4, rc);
      check("postrst_latency", 32'(rc - c0), 32'd2);
      check("postrst_data",    32'(data_out), 32'h00004321);
      check("postrst_err",     32'(err_code), 32'd0);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
